// File: rtl/eth_udp_parser.sv
// Receive-side Ethernet/IPv4/UDP parser: locks on preamble/SFD, filters on MAC, IP,
// port and IPv4 header checksum, and streams the UDP payload with a last-byte marker.
module eth_udp_parser #(
  parameter logic [47:0] FPGA_MAC     = 48'h00_1A_2B_3C_4D_5E,
  parameter logic [31:0] FPGA_IP      = 32'hC0_00_02_92,
  parameter logic [15:0] FPGA_PORT    = 16'd5005,
  parameter int          IDLE_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] received_byte,
  input  logic       byte_valid,
  output logic [7:0] payload,
  output logic       payload_valid,
  output logic       payload_last
);

  typedef enum logic [2:0] {
    HUNT, DST_MAC, SRC_MAC, ETHTYPE, IP_HDR, UDP_HDR, PAYLOAD
  } state_t;

  localparam logic [15:0] IDLE_LAST = 16'(IDLE_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [4:0]  idx;
  logic [3:0]  pre_cnt;
  logic [19:0] csum_acc, csum_sum;
  logic [7:0]  csum_hi;
  logic [15:0] udp_len, rem, idle_cnt;
  logic        vld_p0, last_p0;

  function automatic logic [7:0] mac_byte(input logic [2:0] i);
    case (i)
      3'd0:    return FPGA_MAC[47:40];
      3'd1:    return FPGA_MAC[39:32];
      3'd2:    return FPGA_MAC[31:24];
      3'd3:    return FPGA_MAC[23:16];
      3'd4:    return FPGA_MAC[15:8];
      default: return FPGA_MAC[7:0];
    endcase
  endfunction

  function automatic logic [7:0] ip_byte(input logic [1:0] i);
    case (i)
      2'd0:    return FPGA_IP[31:24];
      2'd1:    return FPGA_IP[23:16];
      2'd2:    return FPGA_IP[15:8];
      default: return FPGA_IP[7:0];
    endcase
  endfunction

  // Two end-around carry folds suffice: ten words never exceed 20 bits.
  function automatic logic [15:0] csum_fold(input logic [19:0] s);
    logic [16:0] f1;
    f1 = {1'b0, s[15:0]} + {13'd0, s[19:16]};
    return f1[15:0] + {15'd0, f1[16]};
  endfunction

  assign csum_sum = csum_acc + {4'd0, csum_hi, received_byte};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= HUNT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state != HUNT && !byte_valid && idle_cnt == IDLE_LAST) begin
      state_nxt = HUNT;
    end else if (byte_valid) begin
      case (state)
        HUNT:
          if (received_byte == 8'hD5 && pre_cnt != 4'd0) state_nxt = DST_MAC;
        DST_MAC:
          if (received_byte != mac_byte(idx[2:0])) state_nxt = HUNT;
          else if (idx == 5'd5)                    state_nxt = SRC_MAC;
        SRC_MAC:
          if (idx == 5'd5) state_nxt = ETHTYPE;
        ETHTYPE:
          if (received_byte != (idx[0] ? 8'h00 : 8'h08)) state_nxt = HUNT;
          else if (idx[0])                              state_nxt = IP_HDR;
        IP_HDR:
          if (idx >= 5'd16 && received_byte != ip_byte(idx[1:0])) state_nxt = HUNT;
          else if (idx == 5'd19)
            state_nxt = (csum_fold(csum_sum) == 16'hFFFF) ? UDP_HDR : HUNT;
        UDP_HDR:
          if ((idx == 5'd2 && received_byte != FPGA_PORT[15:8]) ||
              (idx == 5'd3 && received_byte != FPGA_PORT[7:0]))
            state_nxt = HUNT;
          else if (idx == 5'd7)
            state_nxt = (udp_len > 16'd8) ? PAYLOAD : HUNT;
        PAYLOAD:
          if (rem == 16'd1) state_nxt = HUNT;
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    vld_p0  = byte_valid && state == PAYLOAD;
    last_p0 = vld_p0 && rem == 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx      <= '0;
      pre_cnt  <= '0;
      csum_acc <= '0;
      csum_hi  <= '0;
      udp_len  <= '0;
      rem      <= '0;
      idle_cnt <= '0;
    end else begin
      if (state_nxt != state)                 idx <= '0;
      else if (byte_valid && state != HUNT)   idx <= idx + 5'd1;

      if (state != HUNT)                      pre_cnt <= '0;
      else if (byte_valid)
        pre_cnt <= (received_byte != 8'h55) ? 4'd0 :
                   (pre_cnt == 4'hF)        ? pre_cnt : pre_cnt + 4'd1;

      if (state != IP_HDR) begin
        csum_acc <= '0;
        csum_hi  <= '0;
      end else if (byte_valid) begin
        if (!idx[0]) csum_hi  <= received_byte;
        else         csum_acc <= csum_sum;
      end

      if (state == UDP_HDR && byte_valid) begin
        if (idx == 5'd4) udp_len[15:8] <= received_byte;
        if (idx == 5'd5) udp_len[7:0]  <= received_byte;
      end

      if (state == UDP_HDR && byte_valid && idx == 5'd7) rem <= udp_len - 16'd8;
      else if (vld_p0)                                   rem <= rem - 16'd1;

      if (state == HUNT || byte_valid) idle_cnt <= '0;
      else                             idle_cnt <= idle_cnt + 16'd1;
    end
  end

  // Output register stage: one clock after the sampling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      payload       <= '0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
    end else begin
      payload_valid <= vld_p0;
      payload_last  <= last_p0;
      if (vld_p0) payload <= received_byte;
    end
  end

endmodule

// File: tb/tb_eth_udp_parser.sv
// Randomized frame generator with a field-level accept model and a payload scoreboard.
module tb_eth_udp_parser;
  localparam logic [47:0] MAC  = 48'h00_1A_2B_3C_4D_5E;
  localparam logic [31:0] IP   = 32'hC0_00_02_92;
  localparam logic [15:0] PORT = 16'd5005;
  localparam int          TO   = 64;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] received_byte = 8'h00;
  logic       byte_valid = 1'b0;
  logic [7:0] payload;
  logic       payload_valid, payload_last;

  eth_udp_parser #(.FPGA_MAC(MAC), .FPGA_IP(IP), .FPGA_PORT(PORT), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .received_byte(received_byte), .byte_valid(byte_valid),
    .payload(payload), .payload_valid(payload_valid), .payload_last(payload_last)
  );

  always #10 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [8:0] exp_q[$];
  logic [7:0] pl_q[$];
  logic [7:0] held = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expected {last, byte} per payload strobe.
  always @(negedge clk) begin
    if (!resetn) begin
      held = 8'h00;
    end else if (payload_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_payload_valid", {23'd0, payload_last, payload}, 32'h0);
        checks--;
        check("unexpected_payload_valid", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("payload_byte", {24'd0, payload}, {24'd0, e[7:0]});
        check("payload_last", {31'd0, payload_last}, {31'd0, e[8]});
      end
      held = payload;
    end else begin
      check("payload_hold", {24'd0, payload}, {24'd0, held});
      check("last_without_valid", {31'd0, payload_last}, 32'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
  endtask

  task automatic put(input logic [7:0] b, input int max_gap);
    idle(int'($urandom_range(0, max_gap)));
    @(negedge clk);
    byte_valid    = 1'b1;
    received_byte = b;
  endtask

  task automatic put16(input logic [15:0] w, input int max_gap);
    put(w[15:8], max_gap);
    put(w[7:0], max_gap);
  endtask

  // Builds and sends one frame; payload bytes come from pl_q.
  task automatic send_frame(input logic [47:0] dmac, input logic [15:0] etype,
                            input logic [31:0] dip, input logic [15:0] dport,
                            input logic [15:0] ulen, input bit csum_bad,
                            input int midgap, input int rst_at, input int max_gap);
    logic [7:0]  ip[20];
    logic [15:0] tot, cs;
    int unsigned s;
    bit          accept;
    int          n;
    tot = 16'd20 + ulen;
    ip[0] = 8'h45; ip[1] = 8'h00; ip[2] = tot[15:8]; ip[3] = tot[7:0];
    ip[4] = 8'($urandom); ip[5] = 8'($urandom); ip[6] = 8'h40; ip[7] = 8'h00;
    ip[8] = 8'h40; ip[9] = 8'h11; ip[10] = 8'h00; ip[11] = 8'h00;
    for (int i = 12; i < 16; i++) ip[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) ip[16+i] = dip[31-8*i -: 8];
    s = 0;
    for (int i = 0; i < 10; i++) s += {ip[2*i], ip[2*i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    cs = ~s[15:0];
    if (csum_bad) cs = cs ^ 16'h0001;
    ip[10] = cs[15:8]; ip[11] = cs[7:0];
    // Receiver rule: ones-complement sum of all ten words must be FFFF.
    s = 0;
    for (int i = 0; i < 10; i++) s += {ip[2*i], ip[2*i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    accept = dmac == MAC && etype == 16'h0800 && dip == IP && s == 32'hFFFF &&
             dport == PORT && ulen > 16'd8 && midgap < TO;
    n = (ulen > 16'd8) ? int'(ulen) - 8 : 0;
    if (accept)
      for (int i = 0; i < n; i++)
        if (rst_at < 0 || i < rst_at) exp_q.push_back({i == n - 1, pl_q[i]});

    repeat (7) put(8'h55, max_gap);
    put(8'hD5, max_gap);
    for (int i = 0; i < 6; i++) put(dmac[47-8*i -: 8], max_gap);
    for (int i = 0; i < 6; i++) put(8'($urandom), max_gap);
    put16(etype, max_gap);
    idle(midgap);
    for (int i = 0; i < 20; i++) put(ip[i], max_gap);
    put16(16'($urandom), max_gap);
    put16(dport, max_gap);
    put16(ulen, max_gap);
    put16(16'($urandom), max_gap);
    for (int i = 0; i < pl_q.size(); i++) begin
      put(pl_q[i], max_gap);
      if (i == rst_at) begin
        #2 resetn = 1'b0;
        #1;
        check("rst_payload", {24'd0, payload}, 32'd0);
        check("rst_valid", {31'd0, payload_valid}, 32'd0);
        check("rst_last", {31'd0, payload_last}, 32'd0);
        idle(2);
        resetn = 1'b1;
        check("queue_after_reset", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        return;
      end
    end
    for (int i = 0; i < 4; i++) put(8'($urandom), max_gap);
  endtask

  task automatic set_deadbeef();
    pl_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
  endtask

  initial begin
    resetn = 1'b0;
    idle(3);
    check("reset_payload", {24'd0, payload}, 32'd0);
    check("reset_valid", {31'd0, payload_valid}, 32'd0);
    check("reset_last", {31'd0, payload_last}, 32'd0);
    resetn = 1'b1;
    idle(2);

    set_deadbeef();
    send_frame(MAC, 16'h0800, IP, PORT, 16'd12, 1'b0, 0, -1, 0);
    idle(1);
    send_frame(MAC, 16'h0800, IP, PORT, 16'd12, 1'b0, 0, -1, 0);
    send_frame(48'h10_1A_2B_3C_4D_5E, 16'h0800, IP, PORT, 16'd12, 1'b0, 0, -1, 0);
    send_frame(48'hFF_FF_FF_FF_FF_FF, 16'h0800, IP, PORT, 16'd12, 1'b0, 0, -1, 0);
    send_frame(MAC, 16'h86DD, IP, PORT, 16'd12, 1'b0, 0, -1, 0);
    send_frame(MAC, 16'h0800, IP, PORT, 16'd12, 1'b1, 0, -1, 0);
    send_frame(MAC, 16'h0800, 32'hC0_AA_02_92, PORT, 16'd12, 1'b0, 0, -1, 0);
    send_frame(MAC, 16'h0800, IP, 16'd8001, 16'd12, 1'b0, 0, -1, 0);
    send_frame(MAC, 16'h0800, IP, PORT, 16'd8, 1'b0, 0, -1, 0);
    send_frame(MAC, 16'h0800, IP, PORT, 16'd12, 1'b0, TO - 1, -1, 0);
    send_frame(MAC, 16'h0800, IP, PORT, 16'd12, 1'b0, TO, -1, 0);
    send_frame(MAC, 16'h0800, IP, PORT, 16'd12, 1'b0, 0, 2, 0);
    idle(1);
    send_frame(MAC, 16'h0800, IP, PORT, 16'd12, 1'b0, 0, -1, 0);

    for (int f = 0; f < 40; f++) begin
      logic [47:0] dmac;
      logic [15:0] etype, dport, ulen;
      logic [31:0] dip;
      bit          bad;
      int          plen;
      dmac = MAC; etype = 16'h0800; dip = IP; dport = PORT; bad = 1'b0;
      plen = int'($urandom_range(1, 16));
      pl_q.delete();
      for (int i = 0; i < plen; i++) pl_q.push_back(8'($urandom));
      ulen = 16'(plen + 8);
      case ($urandom_range(0, 7))
        1: dmac  = MAC ^ (48'd1 << $urandom_range(0, 47));
        2: etype = 16'h86DD;
        3: bad   = 1'b1;
        4: dip   = IP ^ (32'd1 << $urandom_range(0, 31));
        5: dport = PORT ^ (16'd1 << $urandom_range(0, 15));
        6: ulen  = 16'($urandom_range(0, 8));
        default: ;
      endcase
      send_frame(dmac, etype, dip, dport, ulen, bad, 0, -1, int'($urandom_range(0, 2)));
      idle(int'($urandom_range(0, 3)));
    end

    idle(10);
    check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
